// File: rtl/arb_pkg.sv
// Shared types and defaults for the add_arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default M/N/CAP, pointer-width helper.
package arb_pkg;

  localparam int M_DEF   = 4;   // requesters
  localparam int N_DEF   = 4;   // counter is N+1 bits
  localparam int CAP_DEF = 20;  // capacity limit

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    CLEAR = 2'd3
  } arb_state_t;

  // Round-robin pointer width; at least one bit so M=1 still elaborates.
  function automatic int ptr_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: first set req bit at or after ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; valid=0 when no request is set.
//
// Ports: req[M] requests, ptr start index, winner one-hot, valid any-request.
module rr_pick #(
  parameter int M  = 4,
  parameter int PW = 2
) (
  input  logic [M-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [M-1:0]  winner,
  output logic          valid
);

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    // Scan M positions starting at ptr; the first hit wins.
    for (int i = 0; i < M; i++) begin
      idx = (int'(ptr) + i) % M;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one counter: issues add strobes, clears, acks.
// Latency: req seen in IDLE -> add next cycle -> ack the cycle after (3-cycle loop).
// Backpressure: requests wait while full (count_in >= CAP); clear always wins.
//
// Ports: clk_N/rst (async active-high), req[M], clr_req, count_in[N:0] in;
//        add, cnt_clr_n, gnt[M], ack[M] registered out; full combinational out.
module add_arbiter
  import arb_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int M   = M_DEF,
  parameter int CAP = CAP_DEF
) (
  input  logic         clk_N,
  input  logic         rst,
  input  logic [M-1:0] req,
  input  logic         clr_req,
  input  logic [N:0]   count_in,
  output logic         add,
  output logic         cnt_clr_n,
  output logic [M-1:0] gnt,
  output logic [M-1:0] ack,
  output logic         full
);

  localparam int         PW    = ptr_w(M);
  localparam logic [N:0] CAP_V = CAP[N:0];

  arb_state_t    state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] win_idx, win_idx_nxt;
  logic [PW-1:0] pick_idx;
  logic          pending, pending_nxt;
  logic [M-1:0]  pick;
  logic          pick_vld;
  logic [M-1:0]  gnt_nxt, ack_nxt;
  logic          add_nxt, clr_n_nxt;

  rr_pick #(.M(M), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_vld)
  );

  // The counter updates on the falling edge of ISSUE, so by the next IDLE
  // this already reflects every granted increment.
  assign full = (count_in >= CAP_V);

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < M; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    pending_nxt = pending;
    win_idx_nxt = win_idx;
    gnt_nxt     = '0;
    ack_nxt     = '0;
    add_nxt     = 1'b0;
    clr_n_nxt   = 1'b1;
    case (state)
      IDLE: begin
        if (clr_req || pending) begin
          state_nxt = CLEAR;
          clr_n_nxt = 1'b0;
        end else if (pick_vld && !full) begin
          state_nxt   = ISSUE;
          gnt_nxt     = pick;
          add_nxt     = 1'b1;
          win_idx_nxt = pick_idx;
        end
      end
      ISSUE: begin
        state_nxt = DONE;
        ack_nxt   = gnt;
        ptr_nxt   = (win_idx == PW'(M - 1)) ? '0 : win_idx + 1'b1;
        // A clear arriving mid-increment is remembered, not dropped.
        if (clr_req) pending_nxt = 1'b1;
      end
      DONE: begin
        state_nxt = IDLE;
        if (clr_req) pending_nxt = 1'b1;
      end
      CLEAR: begin
        state_nxt   = IDLE;
        pending_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt_clr_n resets low so the counter is held clear through reset and
  // released on the first rising edge afterwards.
  always_ff @(posedge clk_N or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      win_idx   <= '0;
      pending   <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      add       <= 1'b0;
      cnt_clr_n <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      win_idx   <= win_idx_nxt;
      pending   <= pending_nxt;
      gnt       <= gnt_nxt;
      ack       <= ack_nxt;
      add       <= add_nxt;
      cnt_clr_n <= clr_n_nxt;
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
module tb_add_arbiter;
  import arb_pkg::*;

  logic       clk_N = 1'b0;
  logic       rst   = 1'b1;

  // Main instance: default CAP=20.
  logic [3:0] req = '0;
  logic       clr_req = 1'b0;
  logic [4:0] count = '0;
  logic       add, cnt_clr_n, full;
  logic [3:0] gnt, ack;

  // Capacity instance: CAP=3.
  logic [3:0] req_c = '0;
  logic       clr_c = 1'b0;
  logic [4:0] count_c = '0;
  logic       add_c, cnt_clr_n_c, full_c;
  logic [3:0] gnt_c, ack_c;

  // Standalone picker.
  logic [3:0] rr_req;
  logic [1:0] rr_ptr;
  logic [3:0] rr_win;
  logic       rr_vld;

  int errors = 0;
  int checks = 0;
  logic [3:0] acks[$];
  int adds;

  always #5 clk_N = ~clk_N;

  add_arbiter #(.N(4), .M(4), .CAP(20)) dut (
    .clk_N(clk_N), .rst(rst), .req(req), .clr_req(clr_req), .count_in(count),
    .add(add), .cnt_clr_n(cnt_clr_n), .gnt(gnt), .ack(ack), .full(full)
  );

  add_arbiter #(.N(4), .M(4), .CAP(3)) dut_c (
    .clk_N(clk_N), .rst(rst), .req(req_c), .clr_req(clr_c), .count_in(count_c),
    .add(add_c), .cnt_clr_n(cnt_clr_n_c), .gnt(gnt_c), .ack(ack_c), .full(full_c)
  );

  rr_pick #(.M(4), .PW(2)) u_rr (
    .req(rr_req), .ptr(rr_ptr), .winner(rr_win), .valid(rr_vld)
  );

  // Counter models: act on the falling edge, clear has priority.
  always @(negedge clk_N) begin
    if (!cnt_clr_n) count <= '0;
    else if (add)   count <= count + 5'd1;
  end
  always @(negedge clk_N) begin
    if (!cnt_clr_n_c) count_c <= '0;
    else if (add_c)   count_c <= count_c + 5'd1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_N);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; clr_req = 1'b0; req_c = '0; clr_c = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_main(input logic [3:0] m, input int n);
    acks.delete(); adds = 0; req = m;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ack != 4'd0) acks.push_back(ack);
      if (add) adds++;
    end
  endtask

  task automatic run_cap(input logic [3:0] m, input int n);
    acks.delete(); adds = 0; req_c = m;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ack_c != 4'd0) acks.push_back(ack_c);
      if (add_c) adds++;
    end
  endtask

  typedef struct {
    logic [3:0] r;
    logic [1:0] p;
    logic [3:0] w;
    logic       v;
  } rr_vec_t;

  rr_vec_t vecs[10];
  logic [3:0] rot[4];

  initial begin
    vecs[0] = '{4'b0000, 2'd0, 4'b0000, 1'b0};
    vecs[1] = '{4'b0001, 2'd0, 4'b0001, 1'b1};
    vecs[2] = '{4'b0001, 2'd1, 4'b0001, 1'b1};
    vecs[3] = '{4'b0101, 2'd1, 4'b0100, 1'b1};
    vecs[4] = '{4'b0101, 2'd3, 4'b0001, 1'b1};
    vecs[5] = '{4'b1111, 2'd2, 4'b0100, 1'b1};
    vecs[6] = '{4'b1000, 2'd0, 4'b1000, 1'b1};
    vecs[7] = '{4'b0110, 2'd3, 4'b0010, 1'b1};
    vecs[8] = '{4'b1010, 2'd2, 4'b1000, 1'b1};
    vecs[9] = '{4'b0011, 2'd1, 4'b0010, 1'b1};
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000;

    for (int i = 0; i < 10; i++) begin
      rr_req = vecs[i].r;
      rr_ptr = vecs[i].p;
      #1;
      check($sformatf("rr_win[%0d]", i), int'(rr_win), int'(vecs[i].w));
      check($sformatf("rr_vld[%0d]", i), int'(rr_vld), int'(vecs[i].v));
    end

    // Reset state.
    tick();
    check("rst_add", int'(add), 0);
    check("rst_gnt", int'(gnt), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_clr_n", int'(cnt_clr_n), 0);
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    rst = 1'b0;
    tick();
    check("clr_n_release", int'(cnt_clr_n), 1);

    // Single request.
    req = 4'b0001;
    tick();
    check("single_add", int'(add), 1);
    check("single_gnt", int'(gnt), 1);
    tick();
    check("single_add_off", int'(add), 0);
    check("single_ack", int'(ack), 1);
    check("single_count", int'(count), 1);
    req = 4'b0011;
    tick();
    check("single_ack_off", int'(ack), 0);
    tick();
    check("ptr1_gnt", int'(gnt), 2);

    // Simultaneous held requests.
    do_reset();
    run_main(4'b0101, 9);
    req = '0;
    check("simul_nacks", acks.size(), 3);
    if (acks.size() == 3) begin
      check("simul_ack0", int'(acks[0]), 1);
      check("simul_ack1", int'(acks[1]), 4);
      check("simul_ack2", int'(acks[2]), 1);
    end
    check("simul_count", int'(count), 3);

    // Clear pulsed during ISSUE.
    do_reset();
    req = 4'b0001;
    tick();
    check("cli_add", int'(add), 1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    req = '0;
    check("cli_ack", int'(ack), 1);
    check("cli_count1", int'(count), 1);
    tick();
    check("cli_idle_clr_n", int'(cnt_clr_n), 1);
    tick();
    check("cli_clr_low", int'(cnt_clr_n), 0);
    tick();
    check("cli_clr_high", int'(cnt_clr_n), 1);
    check("cli_count0", int'(count), 0);

    // Reset during ISSUE.
    do_reset();
    req = 4'b0010;
    tick();
    check("rsti_add_before", int'(add), 1);
    rst = 1'b1;
    req = '0;
    #1;
    check("rsti_add", int'(add), 0);
    check("rsti_gnt", int'(gnt), 0);
    check("rsti_clr_n", int'(cnt_clr_n), 0);
    @(negedge clk_N);
    #1;
    check("rsti_count", int'(count), 0);
    tick();
    rst = 1'b0;
    run_main(4'b0000, 4);
    check("rsti_no_ack", acks.size(), 0);
    check("rsti_no_add", adds, 0);
    req = 4'b0011;
    tick();
    check("rsti_ptr0_gnt", int'(gnt), 1);
    req = '0;

    // Fairness: all held for 48 cycles.
    do_reset();
    run_main(4'b1111, 48);
    req = '0;
    check("fair_nacks", acks.size(), 16);
    for (int i = 0; i < acks.size() && i < 16; i++)
      check($sformatf("fair_ack%0d", i), int'(acks[i]), int'(rot[i % 4]));
    check("fair_count", int'(count), 16);

    // Capacity CAP=3.
    do_reset();
    run_cap(4'b1111, 20);
    check("cap_nacks", acks.size(), 3);
    check("cap_nadds", adds, 3);
    if (acks.size() == 3) begin
      check("cap_ack0", int'(acks[0]), 1);
      check("cap_ack1", int'(acks[1]), 2);
      check("cap_ack2", int'(acks[2]), 4);
    end
    check("cap_full", int'(full_c), 1);
    check("cap_count", int'(count_c), 3);
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
    check("cap_clr_low", int'(cnt_clr_n_c), 0);
    tick();
    check("cap_clr_high", int'(cnt_clr_n_c), 1);
    check("cap_count0", int'(count_c), 0);
    check("cap_full0", int'(full_c), 0);
    tick();
    check("cap_resume_add", int'(add_c), 1);
    check("cap_resume_gnt", int'(gnt_c), 8);
    req_c = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
